// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (core / debug) arbiter onto one synchronous-read memory.
// Each transaction takes one memory cycle followed by one response cycle.
// A request that arrives while the arbiter is idle gets mem_en in the next
// cycle and ready in the cycle after that.
// When both ports are eligible, the port that did not win last time is granted.
// A response cycle may hand the memory straight to the other port, so
// contended grants alternate every two cycles.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   c_req/c_we/c_wstrb/c_addr/c_wdata  core request; fields held until c_ready
//   c_ready, c_rdata              core completion pulse and read data
//   d_req/d_we/d_wstrb/d_addr/d_wdata  debug/loader request, same protocol
//   d_ready, d_rdata              debug completion pulse and read data
//   d_lock                        blocks new core grants while high
//   c_stall                       core request pending without completion
//   mem_en/mem_we/mem_wstrb/mem_addr/mem_wdata  memory cycle outputs
//   mem_rdata                     memory read data, valid one cycle after mem_en
module mem_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            c_req,
  input  logic            c_we,
  input  logic [DW/8-1:0] c_wstrb,
  input  logic [AW-1:0]   c_addr,
  input  logic [DW-1:0]   c_wdata,
  output logic            c_ready,
  output logic [DW-1:0]   c_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_wstrb,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_ready,
  output logic [DW-1:0]   d_rdata,
  input  logic            d_lock,
  output logic            c_stall,
  output logic            mem_en,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_wstrb,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int unsigned SW = DW / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DBG  = 1'b1
  } owner_t;

  state_t  state;
  state_t  state_nxt;
  owner_t  owner;
  owner_t  last_owner;
  owner_t  winner;
  logic    grant;
  logic    core_elig;
  logic    dbg_elig;

  logic          lat_we;
  logic [SW-1:0] lat_wstrb;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and arbitration
  always_comb begin
    core_elig = c_req & ~d_lock;
    dbg_elig  = d_req;
    // In the response cycle the current owner may not win again, which is
    // what lets the other port take the very next memory cycle.
    if (state == S_RESP) begin
      if (owner == OWN_CORE) begin
        core_elig = 1'b0;
      end else begin
        dbg_elig = 1'b0;
      end
    end

    if (core_elig && dbg_elig) begin
      winner = (last_owner == OWN_CORE) ? OWN_DBG : OWN_CORE;
    end else if (core_elig) begin
      winner = OWN_CORE;
    end else begin
      winner = OWN_DBG;
    end

    grant     = 1'b0;
    state_nxt = state;
    case (state)
      S_IDLE, S_RESP: begin
        grant     = core_elig | dbg_elig;
        state_nxt = grant ? S_ACCESS : S_IDLE;
      end
      S_ACCESS: begin
        state_nxt = S_RESP;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Grant bookkeeping and frozen request fields
  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= OWN_CORE;
      last_owner <= OWN_DBG;
      lat_we     <= 1'b0;
      lat_wstrb  <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else if (grant) begin
      owner      <= winner;
      last_owner <= winner;
      if (winner == OWN_CORE) begin
        lat_we    <= c_we;
        lat_wstrb <= c_wstrb;
        lat_addr  <= c_addr;
        lat_wdata <= c_wdata;
      end else begin
        lat_we    <= d_we;
        lat_wstrb <= d_wstrb;
        lat_addr  <= d_addr;
        lat_wdata <= d_wdata;
      end
    end
  end

  // Outputs
  always_comb begin
    mem_en    = (state == S_ACCESS);
    mem_we    = mem_en & lat_we;
    mem_wstrb = mem_en ? lat_wstrb : '0;
    mem_addr  = lat_addr;
    mem_wdata = lat_wdata;
    c_ready   = (state == S_RESP) && (owner == OWN_CORE);
    d_ready   = (state == S_RESP) && (owner == OWN_DBG);
    // Read data is only forwarded to the port being answered.
    c_rdata   = c_ready ? mem_rdata : '0;
    d_rdata   = d_ready ? mem_rdata : '0;
    c_stall   = c_req & ~c_ready;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed bench for mem_arbiter with a
// transaction-level reference model and an SRAM model on the memory side.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        c_req = 1'b0, c_we = 1'b0;
  logic [3:0]  c_wstrb = '0;
  logic [31:0] c_addr = '0, c_wdata = '0;
  logic        c_ready;
  logic [31:0] c_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [3:0]  d_wstrb = '0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        d_lock = 1'b0;
  logic        c_stall;
  logic        mem_en, mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_wstrb(c_wstrb), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ready(c_ready), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .d_lock(d_lock), .c_stall(c_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  function automatic void chk32(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  function automatic void chk1(string name, logic act, logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endfunction

  // SRAM seen by the DUT
  logic [31:0] sram [16];
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= sram[mem_addr[5:2]];
      if (mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) sram[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // Reference model: a grant made at edge g occupies the memory in the cycle
  // after g and answers in the cycle after g+1. A new grant is possible from
  // edge g+2 on, where the previous winner is excluded at exactly g+2.
  typedef struct {
    logic        who;   // 0 core, 1 debug
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
  } txn_t;

  logic [31:0] shadow [16];
  txn_t cur;
  int   t = 0;
  int   last_g = -100;
  logic rr_last = 1'b1;
  logic model_on = 1'b0;
  logic after_rst = 1'b0;
  int   gap;
  logic m_ce, m_de, m_who;

  logic        e_en, e_we, e_cr, e_dr, e_rdchk;
  logic [3:0]  e_wstrb;
  logic [31:0] e_addr, e_wdata, e_rd;

  always @(posedge clk) begin
    t = t + 1;
    if (rst) begin
      last_g    = -100;
      rr_last   = 1'b1;
      cur       = '{default: '0};
      after_rst = 1'b1;
      model_on  = 1'b1;
    end else begin
      after_rst = 1'b0;
      gap  = t - last_g;
      m_ce = c_req && !d_lock;
      m_de = d_req;
      if (gap == 2) begin
        if (cur.who == 1'b0) m_ce = 1'b0;
        else m_de = 1'b0;
      end
      if (gap >= 2 && (m_ce || m_de)) begin
        m_who = (m_ce && m_de) ? !rr_last : !m_ce;
        if (m_who == 1'b0) cur = '{1'b0, c_we, c_wstrb, c_addr, c_wdata, 32'h0};
        else cur = '{1'b1, d_we, d_wstrb, d_addr, d_wdata, 32'h0};
        cur.rd = shadow[cur.addr[5:2]];
        if (cur.we)
          for (int b = 0; b < 4; b++)
            if (cur.wstrb[b]) shadow[cur.addr[5:2]][8*b +: 8] = cur.wdata[8*b +: 8];
        last_g  = t;
        rr_last = m_who;
      end
    end
    e_en    = (last_g == t);
    e_we    = e_en && cur.we;
    e_wstrb = e_en ? cur.wstrb : 4'h0;
    e_addr  = cur.addr;
    e_wdata = cur.wdata;
    e_cr    = (last_g == t - 1) && !cur.who;
    e_dr    = (last_g == t - 1) && cur.who;
    e_rdchk = (last_g == t - 1) && !cur.we;
    e_rd    = cur.rd;
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk1 ("mem_en", mem_en, e_en);
      chk1 ("mem_we", mem_we, e_we);
      chk32("mem_wstrb", 32'(mem_wstrb), 32'(e_wstrb));
      chk32("mem_addr", mem_addr, e_addr);
      chk32("mem_wdata", mem_wdata, e_wdata);
      chk1 ("c_ready", c_ready, e_cr);
      chk1 ("d_ready", d_ready, e_dr);
      chk1 ("c_stall", c_stall, c_req && !e_cr);
      if (e_cr && e_rdchk) chk32("c_rdata", c_rdata, e_rd);
      if (e_dr && e_rdchk) chk32("d_rdata", d_rdata, e_rd);
      if (after_rst) begin
        chk32("c_rdata_rst", c_rdata, 32'h0);
        chk32("d_rdata_rst", d_rdata, 32'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1; c_req = 1'b0; d_req = 1'b0; d_lock = 1'b0;
    c_we = 1'b0; d_we = 1'b0;
    tick();
    at_neg();
    chk1 ("rst_mem_en", mem_en, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk1 ("rst_c_ready", c_ready, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  int cc, dc;
  logic c_act, d_act;

  initial begin
    for (int i = 0; i < 16; i++) begin
      sram[i]   = 32'(i) * 32'h01010101;
      shadow[i] = 32'(i) * 32'h01010101;
    end
    sram[4]   = 32'hDEADBEEF;
    shadow[4] = 32'hDEADBEEF;

    // Single core read
    do_reset();
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
    at_neg();
    at_neg();
    chk1 ("rd_mem_en_c1", mem_en, 1'b1);
    chk32("rd_addr_c1", mem_addr, 32'h10);
    at_neg();
    chk1 ("rd_c_ready_c2", c_ready, 1'b1);
    chk32("rd_c_rdata_c2", c_rdata, 32'hDEADBEEF);
    tick();
    c_req = 1'b0;
    repeat (3) tick();

    // Simultaneous first requests
    do_reset();
    c_req = 1'b1; c_addr = 32'h8; d_req = 1'b1; d_we = 1'b0; d_addr = 32'hC;
    at_neg();
    at_neg();
    chk32("tie_addr_c1", mem_addr, 32'h8);
    at_neg();
    chk1 ("tie_c_ready_c2", c_ready, 1'b1);
    chk1 ("tie_d_ready_c2", d_ready, 1'b0);
    tick();
    c_req = 1'b0;
    at_neg();
    chk1 ("tie_mem_en_c3", mem_en, 1'b1);
    chk32("tie_addr_c3", mem_addr, 32'hC);
    at_neg();
    chk1 ("tie_d_ready_c4", d_ready, 1'b1);
    tick();
    d_req = 1'b0;
    repeat (3) tick();

    // Continuous contention
    do_reset();
    c_req = 1'b1; d_req = 1'b1;
    cc = 0; dc = 0;
    at_neg();
    for (int k = 1; k <= 16; k++) begin
      at_neg();
      chk1("cont_c_ready", c_ready, (k % 2 == 0) && ((k / 2) % 2 == 1));
      chk1("cont_d_ready", d_ready, (k % 2 == 0) && ((k / 2) % 2 == 0));
      if (c_ready) cc++;
      if (d_ready) dc++;
    end
    chk32("cont_core_count", 32'(cc), 32'd4);
    chk32("cont_dbg_count", 32'(dc), 32'd4);
    tick();
    c_req = 1'b0; d_req = 1'b0;
    repeat (4) tick();

    // d_lock blocks the core
    do_reset();
    d_lock = 1'b1; c_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      at_neg();
      chk1("lock_mem_en", mem_en, 1'b0);
      chk1("lock_c_stall", c_stall, 1'b1);
    end
    tick();
    d_lock = 1'b0;
    at_neg();
    at_neg();
    chk1("unlock_mem_en_c1", mem_en, 1'b1);
    at_neg();
    chk1("unlock_c_ready_c2", c_ready, 1'b1);
    tick();
    c_req = 1'b0;
    repeat (2) tick();

    // Debug write
    d_req = 1'b1; d_we = 1'b1; d_wstrb = 4'b0011; d_addr = 32'h40; d_wdata = 32'h1234ABCD;
    at_neg();
    at_neg();
    chk1 ("dw_mem_en", mem_en, 1'b1);
    chk1 ("dw_mem_we", mem_we, 1'b1);
    chk32("dw_wstrb", 32'(mem_wstrb), 32'h3);
    chk32("dw_addr", mem_addr, 32'h40);
    chk32("dw_wdata", mem_wdata, 32'h1234ABCD);
    at_neg();
    chk1("dw_d_ready", d_ready, 1'b1);
    chk1("dw_mem_we_off", mem_we, 1'b0);
    tick();
    d_req = 1'b0; d_we = 1'b0;
    repeat (2) tick();

    // Request dropped right after grant
    d_req = 1'b1; d_addr = 32'h4;
    at_neg();
    tick();
    d_req = 1'b0;
    at_neg();
    chk1("drop_mem_en", mem_en, 1'b1);
    at_neg();
    chk1("drop_d_ready", d_ready, 1'b1);
    repeat (2) tick();

    // Reset in the memory cycle
    do_reset();
    c_req = 1'b1; c_addr = 32'h10;
    at_neg();
    tick();
    rst = 1'b1;
    at_neg();
    chk1("rstacc_mem_en_c1", mem_en, 1'b1);
    tick();
    rst = 1'b0;
    at_neg();
    chk1("rstacc_mem_en_c2", mem_en, 1'b0);
    chk1("rstacc_c_ready_c2", c_ready, 1'b0);
    at_neg();
    chk1("rstacc_mem_en_c3", mem_en, 1'b1);
    at_neg();
    chk1("rstacc_c_ready_c4", c_ready, 1'b1);
    tick();
    c_req = 1'b0;
    repeat (3) tick();

    // Randomized traffic
    do_reset();
    c_act = 1'b0; d_act = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      at_neg();
      if (c_ready) c_act = 1'b0;
      if (d_ready) d_act = 1'b0;
      tick();
      rst = ($urandom_range(0, 199) == 0);
      if (!c_act && $urandom_range(0, 2) == 0) begin
        c_act = 1'b1;
        c_we = 1'($urandom); c_wstrb = 4'($urandom);
        c_addr = 32'($urandom_range(0, 15)) << 2; c_wdata = $urandom;
      end
      if (!d_act && $urandom_range(0, 2) == 0) begin
        d_act = 1'b1;
        d_we = 1'($urandom); d_wstrb = 4'($urandom);
        d_addr = 32'($urandom_range(0, 15)) << 2; d_wdata = $urandom;
      end
      if (d_lock) begin
        if ($urandom_range(0, 3) == 0) d_lock = 1'b0;
      end else if ($urandom_range(0, 31) == 0) begin
        d_lock = 1'b1;
      end
      c_req = c_act;
      d_req = d_act;
    end
    tick();
    c_req = 1'b0; d_req = 1'b0; d_lock = 1'b0; rst = 1'b0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
